date_set_ctrl: RTL and testbench
================================

Name: date_set_ctrl

Overview:
- Button-driven date editor; the write-side counterpart of the day/month/year counter chain.
- Captures the running BCD date, lets the user edit year, then month, then day with UP/DOWN pulses, and validates the date (days-in-month, leap year).
- Issues a one-cycle LOAD strobe with the new BCD date to the counter chain's load inputs.
- Sits beside the counter chain; driven by debounced single-cycle button pulses and the 1 Hz ENABLE tick.

Parameters:
- TIMEOUT_SEC, 30: number of ENABLE ticks with no button activity after which an edit is abandoned.
- YEAR_MAX, 199: largest year value (binary). Legal range is 0..YEAR_MAX, carried as 3-digit BCD.

Ports:
- CLK  input  1  system clock
- RESET  input  1  asynchronous, active-high reset
- ENABLE  input  1  1 Hz single-cycle tick (from SEC1)
- BTN_MODE  input  1  debounced single-cycle pulse: enter edit / advance field
- BTN_UP  input  1  debounced single-cycle pulse: increment current field
- BTN_DOWN  input  1  debounced single-cycle pulse: decrement current field
- cur_year  input  12  running year, BCD {hundreds, tens, ones}
- cur_month  input  8  running month, BCD 01..12
- cur_day  input  8  running day, BCD 01..31
- set_year  output  12  edited year, BCD
- set_month  output  8  edited month, BCD
- set_day  output  8  edited day, BCD
- LOAD  output  1  one-cycle strobe: counter chain loads set_*
- EDITING  output  1  high in any edit state (display blink enable)
- field_sel  output  2  0 = none, 1 = year, 2 = month, 3 = day (blink select)

Behaviour:
- Reset values: state IDLE; set_year = 12'h000; set_month = 8'h01; set_day = 8'h01; LOAD = 0; EDITING = 0; field_sel = 0.
- Reset is asynchronous and may arrive mid-edit: the edit is dropped and no LOAD is issued.
- FSM states: IDLE, ED_YEAR, ED_MONTH, ED_DAY, COMMIT.
- IDLE:
  - UP and DOWN are ignored.
  - On BTN_MODE: register cur_year/cur_month/cur_day into set_* and go to ED_YEAR on the next edge.
- ED_YEAR:
  - UP: +1, wrapping YEAR_MAX to 0.
  - DOWN: -1, wrapping 0 to YEAR_MAX.
  - Arithmetic is BCD digit-wise with decimal carry/borrow. No non-BCD code may ever appear on set_year.
  - MODE: go to ED_MONTH.
- ED_MONTH:
  - UP/DOWN step 01..12 with wrap (12+1 = 01, 01-1 = 12).
  - MODE: go to ED_DAY.
  - On the MODE edge, set_day is clamped to dim (days in set_month/set_year) when set_day > dim.
- ED_DAY:
  - UP/DOWN step 01..dim with wrap (dim+1 = 01, 01-1 = dim).
  - MODE: go to COMMIT.
- dim:
  - 31 for months 01,03,05,07,08,10,12; 30 for 04,06,09,11.
  - 29 for month 02 when leap, else 28.
  - leap is true iff year%4 == 0 and (year%100 != 0 or year%400 == 0), with year taken as the binary value of set_year. Year 000 is leap; year 100 is not.
- COMMIT:
  - LOAD = 1 for exactly one cycle, then IDLE.
  - set_* hold the committed date during the LOAD cycle and stay held in IDLE afterwards.
- Latency: a button pulse at edge N updates set_*/state at edge N+1. LOAD is high in the cycle after the day-field MODE pulse is sampled.
- Simultaneous inputs:
  - MODE together with UP/DOWN: MODE wins and the value is unchanged.
  - UP and DOWN together: no change.
- Timeout:
  - An idle counter clears on any button pulse and increments on ENABLE while in an edit state.
  - When it reaches TIMEOUT_SEC, go to IDLE with no LOAD. set_* retain their values and are recaptured on the next entry.
- EDITING = 1 in ED_YEAR, ED_MONTH and ED_DAY.
- field_sel follows the state: 1/2/3 in the edit states, 0 in IDLE and COMMIT.
- Inputs cur_* are sampled only at edit entry; changes during edit are ignored.

Test Plan:
- Reset mid-edit:
  - Stimulus: reset asserted in ED_DAY with set_day = 8'h15, no clock edge.
  - Required: set_day = 8'h01, EDITING = 0, field_sel = 0, LOAD = 0 immediately, and LOAD never pulses afterwards.
- Capture and commit:
  - Stimulus: cur = 023/12/31; MODE, MODE, MODE, MODE.
  - Required: exactly one LOAD cycle with set_* = 12'h023 / 8'h12 / 8'h31; EDITING back to 0.
- BCD wrap:
  - Stimulus: year 199 + UP.
  - Required: 12'h000. Then DOWN gives 12'h199; year 009 + UP gives 12'h010; month 12 + UP gives 8'h01; month 01 + DOWN gives 8'h12.
- Day clamp and leap:
  - Year 024, month 02, day 31, MODE: day = 8'h29.
  - Year 100, month 02, day 29, MODE: day = 8'h28.
  - In ED_DAY at 8'h28 of 100/02, UP gives 8'h01.
- Timeout:
  - Stimulus: enter edit, then TIMEOUT_SEC ENABLE ticks with no button.
  - Required: IDLE and no LOAD. A button pulse at tick 29 restarts the count.
- Simultaneous pulses:
  - MODE + UP in ED_MONTH: advances to ED_DAY and month is unchanged.
  - UP + DOWN: no change.

Source files
------------

// File: rtl/date_set_ctrl.sv
// Button-driven BCD date editor: captures the running date, edits year/month/day, validates, strobes LOAD.
// Latency: a button pulse sampled at edge N updates set_*/state at edge N+1; LOAD is high the cycle after the day MODE.
// Backpressure: none; single-cycle pulses are consumed as they arrive, the counter chain must accept LOAD at once.
module date_set_ctrl #(
  parameter int TIMEOUT_SEC = 30,
  parameter int YEAR_MAX    = 199
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        BTN_MODE,
  input  logic        BTN_UP,
  input  logic        BTN_DOWN,
  input  logic [11:0] cur_year,
  input  logic [7:0]  cur_month,
  input  logic [7:0]  cur_day,
  output logic [11:0] set_year,
  output logic [7:0]  set_month,
  output logic [7:0]  set_day,
  output logic        LOAD,
  output logic        EDITING,
  output logic [1:0]  field_sel
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ED_YEAR  = 3'd1,
    ED_MONTH = 3'd2,
    ED_DAY   = 3'd3,
    COMMIT   = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT_SEC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_SEC - 1);
  localparam logic [9:0] YMAX_BIN = 10'(YEAR_MAX);
  localparam logic [3:0] YMAX_H   = 4'((YEAR_MAX / 100) % 10);
  localparam logic [3:0] YMAX_T   = 4'((YEAR_MAX / 10) % 10);
  localparam logic [3:0] YMAX_O   = 4'(YEAR_MAX % 10);
  localparam logic [11:0] YMAX_BCD = {YMAX_H, YMAX_T, YMAX_O};

  state_t           state_q, state_d;
  logic [11:0]      year_q, year_d;
  logic [7:0]       month_q, month_d;
  logic [7:0]       day_q, day_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [9:0] year_bin;
  logic       leap;
  logic [7:0] dim;
  logic       step_up, step_dn, any_btn, in_edit;

  // Two-digit BCD increment; the caller handles the field's upper wrap.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [11:0] bcd3_inc(input logic [11:0] v);
    if (v[7:0] == 8'h99) return {v[11:8] + 4'd1, 8'h00};
    else                 return {v[11:8], bcd2_inc(v[7:0])};
  endfunction

  function automatic logic [11:0] bcd3_dec(input logic [11:0] v);
    if (v[7:0] == 8'h00) return {v[11:8] - 4'd1, 8'h99};
    else                 return {v[11:8], bcd2_dec(v[7:0])};
  endfunction

  // Binary year drives the range wrap and the divisible-by-4 test.
  assign year_bin = 10'(year_q[11:8]) * 10'd100 + 10'(year_q[7:4]) * 10'd10 + 10'(year_q[3:0]);

  // Century years (low two digits 00) are leap only when hundreds is a multiple of 4.
  assign leap = (year_bin[1:0] == 2'b00) && ((year_q[7:0] != 8'h00) || (year_q[9:8] == 2'b00));

  // Days in the month currently held in set_month/set_year, as BCD.
  always_comb begin
    dim = 8'h31;
    case (month_q)
      8'h02:                      dim = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: dim = 8'h30;
      default:                    dim = 8'h31;
    endcase
  end

  // MODE has priority over UP/DOWN, and UP together with DOWN cancels.
  assign any_btn = BTN_MODE | BTN_UP | BTN_DOWN;
  assign step_up = BTN_UP & ~BTN_DOWN & ~BTN_MODE;
  assign step_dn = BTN_DOWN & ~BTN_UP & ~BTN_MODE;
  assign in_edit = (state_q == ED_YEAR) || (state_q == ED_MONTH) || (state_q == ED_DAY);

  // State, edited date and inactivity counter; reset drops any edit in progress.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      year_q  <= 12'h000;
      month_q <= 8'h01;
      day_q   <= 8'h01;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: field editing with wrap, day clamp on leaving month, inactivity timeout.
  always_comb begin
    state_d = state_q;
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (BTN_MODE) begin
          year_d  = cur_year;
          month_d = cur_month;
          day_d   = cur_day;
          state_d = ED_YEAR;
        end
      end
      ED_YEAR: begin
        if (BTN_MODE) begin
          state_d = ED_MONTH;
        end else if (step_up) begin
          year_d = (year_bin >= YMAX_BIN) ? 12'h000 : bcd3_inc(year_q);
        end else if (step_dn) begin
          year_d = ((year_bin == 10'd0) || (year_bin > YMAX_BIN)) ? YMAX_BCD : bcd3_dec(year_q);
        end
      end
      ED_MONTH: begin
        if (BTN_MODE) begin
          state_d = ED_DAY;
          if (day_q > dim) day_d = dim;
        end else if (step_up) begin
          month_d = (month_q >= 8'h12) ? 8'h01 : bcd2_inc(month_q);
        end else if (step_dn) begin
          month_d = (month_q <= 8'h01) ? 8'h12 : bcd2_dec(month_q);
        end
      end
      ED_DAY: begin
        if (BTN_MODE) begin
          state_d = COMMIT;
        end else if (step_up) begin
          day_d = (day_q >= dim) ? 8'h01 : bcd2_inc(day_q);
        end else if (step_dn) begin
          day_d = (day_q <= 8'h01) ? dim : bcd2_dec(day_q);
        end
      end
      COMMIT: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (in_edit) begin
      if (any_btn) begin
        cnt_d = '0;
      end else if (ENABLE) begin
        if (cnt_q >= CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    LOAD      = 1'b0;
    EDITING   = 1'b0;
    field_sel = 2'd0;
    case (state_q)
      ED_YEAR:  begin EDITING = 1'b1; field_sel = 2'd1; end
      ED_MONTH: begin EDITING = 1'b1; field_sel = 2'd2; end
      ED_DAY:   begin EDITING = 1'b1; field_sel = 2'd3; end
      COMMIT:   LOAD = 1'b1;
      default:  ;
    endcase
  end

  assign set_year  = year_q;
  assign set_month = month_q;
  assign set_day   = day_q;

endmodule

// File: tb/tb_date_set_ctrl.sv
module tb_date_set_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, ENABLE, BTN_MODE, BTN_UP, BTN_DOWN;
  logic [11:0] cur_year;
  logic [7:0]  cur_month, cur_day;
  logic [11:0] set_year;
  logic [7:0]  set_month, set_day;
  logic        LOAD, EDITING;
  logic [1:0]  field_sel;

  typedef struct packed {
    logic [11:0] y;
    logic [7:0]  m;
    logic [7:0]  d;
  } date_t;

  date_t exp_q[$];
  int total = 0;
  int bad = 0;
  int load_cnt = 0;

  date_set_ctrl #(.TIMEOUT_SEC(30), .YEAR_MAX(199)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
    .BTN_MODE(BTN_MODE), .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN),
    .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .set_year(set_year), .set_month(set_month), .set_day(set_day),
    .LOAD(LOAD), .EDITING(EDITING), .field_sel(field_sel)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every LOAD must match the oldest expected commit.
  always @(negedge CLK) begin
    if (LOAD === 1'b1) begin
      date_t e;
      total++;
      load_cnt++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_load got=%h/%h/%h", set_year, set_month, set_day);
      end else begin
        e = exp_q.pop_front();
        if ({set_year, set_month, set_day} !== e) begin
          bad++;
          $display("FAIL load_data got=%h/%h/%h exp=%h/%h/%h", set_year, set_month, set_day, e.y, e.m, e.d);
        end
      end
    end
  end

  task automatic press(input logic m, input logic u, input logic d);
    @(negedge CLK);
    BTN_MODE = m; BTN_UP = u; BTN_DOWN = d;
    @(negedge CLK);
    BTN_MODE = 1'b0; BTN_UP = 1'b0; BTN_DOWN = 1'b0;
  endtask

  task automatic tick();
    @(negedge CLK);
    ENABLE = 1'b1;
    @(negedge CLK);
    ENABLE = 1'b0;
  endtask

  task automatic enter(input logic [11:0] y, input logic [7:0] m, input logic [7:0] d);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    cur_year = y; cur_month = m; cur_day = d;
    press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    RESET = 1'b1; ENABLE = 1'b0; BTN_MODE = 1'b0; BTN_UP = 1'b0; BTN_DOWN = 1'b0;
    cur_year = 12'h000; cur_month = 8'h01; cur_day = 8'h01;
    repeat (3) @(negedge CLK);
    total++;
    if ({set_year, set_month, set_day} !== {12'h000, 8'h01, 8'h01}) begin
      bad++; $display("FAIL reset_date got=%h/%h/%h exp=000/01/01", set_year, set_month, set_day);
    end
    total++;
    if ({LOAD, EDITING, field_sel} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b%b%0d exp=000", LOAD, EDITING, field_sel);
    end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_capture_commit();
    int l0;
    cur_year = 12'h023; cur_month = 8'h12; cur_day = 8'h31;
    press(1'b1, 1'b0, 1'b0);
    total++;
    if ({set_year, set_month, set_day} !== {12'h023, 8'h12, 8'h31}) begin
      bad++; $display("FAIL capture got=%h/%h/%h exp=023/12/31", set_year, set_month, set_day);
    end
    total++;
    if ({EDITING, field_sel} !== 3'b101) begin
      bad++; $display("FAIL capture_field got=%b/%0d exp=1/1", EDITING, field_sel);
    end
    cur_year = 12'h155; cur_month = 8'h03; cur_day = 8'h07;
    press(1'b1, 1'b0, 1'b0);
    total++;
    if (field_sel !== 2'd2) begin
      bad++; $display("FAIL field_month got=%0d exp=2", field_sel);
    end
    press(1'b1, 1'b0, 1'b0);
    total++;
    if ({field_sel, set_day} !== {2'd3, 8'h31}) begin
      bad++; $display("FAIL field_day got=%0d/%h exp=3/31", field_sel, set_day);
    end
    l0 = load_cnt;
    exp_q.push_back({12'h023, 8'h12, 8'h31});
    press(1'b1, 1'b0, 1'b0);
    total++;
    if ({EDITING, field_sel} !== 3'b000) begin
      bad++; $display("FAIL commit_flags got=%b/%0d exp=0/0", EDITING, field_sel);
    end
    repeat (3) @(negedge CLK);
    total++;
    if (load_cnt !== l0 + 1) begin
      bad++; $display("FAIL commit_count got=%0d exp=%0d", load_cnt - l0, 1);
    end
    total++;
    if ({LOAD, set_year, set_month, set_day} !== {1'b0, 12'h023, 8'h12, 8'h31}) begin
      bad++; $display("FAIL commit_hold got=%b %h/%h/%h exp=0 023/12/31", LOAD, set_year, set_month, set_day);
    end
  endtask

  task automatic test_bcd_wrap();
    enter(12'h199, 8'h12, 8'h05);
    press(1'b0, 1'b1, 1'b0);
    total++;
    if (set_year !== 12'h000) begin
      bad++; $display("FAIL year_up_wrap got=%h exp=000", set_year);
    end
    press(1'b0, 1'b0, 1'b1);
    total++;
    if (set_year !== 12'h199) begin
      bad++; $display("FAIL year_down_wrap got=%h exp=199", set_year);
    end
    press(1'b0, 1'b0, 1'b1);
    total++;
    if (set_year !== 12'h198) begin
      bad++; $display("FAIL year_down got=%h exp=198", set_year);
    end
    enter(12'h009, 8'h12, 8'h05);
    press(1'b0, 1'b1, 1'b0);
    total++;
    if (set_year !== 12'h010) begin
      bad++; $display("FAIL year_carry got=%h exp=010", set_year);
    end
    press(1'b0, 1'b0, 1'b1);
    total++;
    if (set_year !== 12'h009) begin
      bad++; $display("FAIL year_borrow got=%h exp=009", set_year);
    end
    enter(12'h100, 8'h12, 8'h05);
    press(1'b0, 1'b0, 1'b1);
    total++;
    if (set_year !== 12'h099) begin
      bad++; $display("FAIL year_borrow2 got=%h exp=099", set_year);
    end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    total++;
    if (set_month !== 8'h01) begin
      bad++; $display("FAIL month_up_wrap got=%h exp=01", set_month);
    end
    press(1'b0, 1'b0, 1'b1);
    total++;
    if (set_month !== 8'h12) begin
      bad++; $display("FAIL month_down_wrap got=%h exp=12", set_month);
    end
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    total++;
    if (set_month !== 8'h09) begin
      bad++; $display("FAIL month_borrow got=%h exp=09", set_month);
    end
    press(1'b0, 1'b1, 1'b0);
    total++;
    if (set_month !== 8'h10) begin
      bad++; $display("FAIL month_carry got=%h exp=10", set_month);
    end
  endtask

  task automatic test_clamp_leap();
    enter(12'h024, 8'h02, 8'h31);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    total++;
    if (set_day !== 8'h29) begin
      bad++; $display("FAIL clamp_leap024 got=%h exp=29", set_day);
    end
    press(1'b0, 1'b1, 1'b0);
    total++;
    if (set_day !== 8'h01) begin
      bad++; $display("FAIL day_wrap_29 got=%h exp=01", set_day);
    end
    press(1'b0, 1'b0, 1'b1);
    total++;
    if (set_day !== 8'h29) begin
      bad++; $display("FAIL day_down_29 got=%h exp=29", set_day);
    end
    enter(12'h100, 8'h02, 8'h29);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    total++;
    if (set_day !== 8'h28) begin
      bad++; $display("FAIL clamp_100 got=%h exp=28", set_day);
    end
    press(1'b0, 1'b1, 1'b0);
    total++;
    if (set_day !== 8'h01) begin
      bad++; $display("FAIL day_wrap_28 got=%h exp=01", set_day);
    end
    enter(12'h000, 8'h02, 8'h29);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    total++;
    if (set_day !== 8'h29) begin
      bad++; $display("FAIL leap_000 got=%h exp=29", set_day);
    end
    enter(12'h023, 8'h04, 8'h31);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    total++;
    if (set_day !== 8'h30) begin
      bad++; $display("FAIL clamp_apr got=%h exp=30", set_day);
    end
    press(1'b0, 1'b0, 1'b1);
    total++;
    if (set_day !== 8'h29) begin
      bad++; $display("FAIL day_borrow got=%h exp=29", set_day);
    end
  endtask

  task automatic test_simultaneous();
    enter(12'h077, 8'h05, 8'h20);
    press(1'b0, 1'b1, 1'b1);
    total++;
    if ({field_sel, set_year} !== {2'd1, 12'h077}) begin
      bad++; $display("FAIL updown_year got=%0d/%h exp=1/077", field_sel, set_year);
    end
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    total++;
    if ({field_sel, set_month} !== {2'd3, 8'h05}) begin
      bad++; $display("FAIL mode_up_month got=%0d/%h exp=3/05", field_sel, set_month);
    end
    press(1'b0, 1'b1, 1'b1);
    total++;
    if (set_day !== 8'h20) begin
      bad++; $display("FAIL updown_day got=%h exp=20", set_day);
    end
  endtask

  task automatic test_timeout();
    enter(12'h050, 8'h06, 8'h15);
    repeat (29) tick();
    total++;
    if ({EDITING, field_sel} !== 3'b101) begin
      bad++; $display("FAIL timeout_early got=%b/%0d exp=1/1", EDITING, field_sel);
    end
    press(1'b0, 1'b1, 1'b0);
    repeat (29) tick();
    total++;
    if ({EDITING, set_year} !== {1'b1, 12'h051}) begin
      bad++; $display("FAIL timeout_restart got=%b/%h exp=1/051", EDITING, set_year);
    end
    tick();
    total++;
    if ({EDITING, field_sel, LOAD} !== 4'b0000) begin
      bad++; $display("FAIL timeout_idle got=%b/%0d/%b exp=0/0/0", EDITING, field_sel, LOAD);
    end
    total++;
    if ({set_year, set_month, set_day} !== {12'h051, 8'h06, 8'h15}) begin
      bad++; $display("FAIL timeout_retain got=%h/%h/%h exp=051/06/15", set_year, set_month, set_day);
    end
    press(1'b0, 1'b1, 1'b0);
    total++;
    if ({EDITING, set_year} !== {1'b0, 12'h051}) begin
      bad++; $display("FAIL idle_up_ignored got=%b/%h exp=0/051", EDITING, set_year);
    end
    cur_year = 12'h088; cur_month = 8'h08; cur_day = 8'h08;
    press(1'b1, 1'b0, 1'b0);
    total++;
    if ({field_sel, set_year, set_month, set_day} !== {2'd1, 12'h088, 8'h08, 8'h08}) begin
      bad++; $display("FAIL recapture got=%0d %h/%h/%h exp=1 088/08/08", field_sel, set_year, set_month, set_day);
    end
  endtask

  task automatic test_back_to_back();
    int l0;
    enter(12'h150, 8'h01, 8'h31);
    l0 = load_cnt;
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    exp_q.push_back({12'h151, 8'h12, 8'h31});
    press(1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    cur_year = 12'h001; cur_month = 8'h04; cur_day = 8'h30;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    exp_q.push_back({12'h001, 8'h04, 8'h30});
    press(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    total++;
    if (load_cnt !== l0 + 2) begin
      bad++; $display("FAIL b2b_count got=%0d exp=2", load_cnt - l0);
    end
  endtask

  task automatic test_reset_midedit();
    int l0;
    enter(12'h010, 8'h03, 8'h15);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    total++;
    if ({field_sel, set_day} !== {2'd3, 8'h15}) begin
      bad++; $display("FAIL midedit_pre got=%0d/%h exp=3/15", field_sel, set_day);
    end
    l0 = load_cnt;
    #2 RESET = 1'b1;
    #1;
    total++;
    if ({set_day, EDITING, field_sel, LOAD} !== {8'h01, 1'b0, 2'd0, 1'b0}) begin
      bad++; $display("FAIL midedit_reset got=%h/%b/%0d/%b exp=01/0/0/0", set_day, EDITING, field_sel, LOAD);
    end
    @(negedge CLK);
    RESET = 1'b0;
    repeat (10) @(negedge CLK);
    total++;
    if (load_cnt !== l0) begin
      bad++; $display("FAIL midedit_noload got=%0d exp=%0d", load_cnt, l0);
    end
  endtask

  initial begin
    test_reset();
    test_capture_commit();
    test_bcd_wrap();
    test_clamp_leap();
    test_simultaneous();
    test_timeout();
    test_back_to_back();
    test_reset_midedit();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL missing_loads got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
